// File: rtl/relu_maxpool2x2.sv
// ReLU followed by 2x2 stride-2 max pooling on a raster-ordered pixel stream.
// Row-0 horizontal pair maxima park in a half-width line buffer; pooled pixels emerge on row 1 of each pair.
module relu_maxpool2x2 #(
   parameter int DATA_WIDTH = 16,
   parameter int LINE_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_eol,
   input  logic                  in_eof,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_eol,
   output logic                  out_eof,
   output logic                  err
);

   // col must be able to hold LINE_WIDTH itself, the saturation value for overlong rows
   localparam int COL_W = $clog2(LINE_WIDTH + 1);
   localparam int AW    = (LINE_WIDTH > 2) ? $clog2(LINE_WIDTH / 2) : 1;
   localparam int DEPTH = LINE_WIDTH / 2;
   localparam logic [COL_W-1:0] COL_SAT  = COL_W'(LINE_WIDTH);
   localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
   localparam logic [COL_W-1:0] COL_ZERO = {COL_W{1'b0}};

   function automatic logic [DATA_WIDTH-1:0] relu(input logic [DATA_WIDTH-1:0] v);
      return v[DATA_WIDTH-1] ? {DATA_WIDTH{1'b0}} : v;
   endfunction

   function automatic logic [DATA_WIDTH-1:0] umax(input logic [DATA_WIDTH-1:0] a,
                                                  input logic [DATA_WIDTH-1:0] b);
      return (a > b) ? a : b;
   endfunction

   logic [COL_W-1:0]      col_q, col_d;
   logic                  par_q, par_d;
   logic [DATA_WIDTH-1:0] h_q, h_d;
   logic [DATA_WIDTH-1:0] rd_q, rd_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic                  out_valid_q, out_valid_d;
   logic                  out_eol_q, out_eol_d;
   logic                  out_eof_q, out_eof_d;
   logic                  err_q, err_d;
   logic [DATA_WIDTH-1:0] lbuf_q [DEPTH];

   logic                  wr_en_s;
   logic [AW-1:0]         addr_s;
   logic [DATA_WIDTH-1:0] r_s;
   logic [DATA_WIDTH-1:0] m_s;
   logic                  eol_s;

   // Next-state: column/row tracking, pair max, pooled output and framing errors
   always_comb begin
      r_s         = relu(in_data);
      m_s         = umax(h_q, r_s);
      addr_s      = col_q[AW:1];
      eol_s       = in_eol | in_eof;
      col_d       = col_q;
      par_d       = par_q;
      h_d         = h_q;
      rd_d        = rd_q;
      out_data_d  = out_data_q;
      out_valid_d = 1'b0;
      out_eol_d   = 1'b0;
      out_eof_d   = 1'b0;
      err_d       = err_q;
      wr_en_s     = 1'b0;
      if (in_valid) begin
         if (col_q == COL_SAT) begin
            err_d = 1'b1;
         end else if (!col_q[0]) begin
            // even column: the line buffer read for this pair is issued one beat early
            h_d   = r_s;
            rd_d  = lbuf_q[addr_s];
            col_d = col_q + COL_ONE;
            err_d = err_q | eol_s;
         end else begin
            col_d = col_q + COL_ONE;
            if (par_q) begin
               out_valid_d = 1'b1;
               out_data_d  = umax(rd_q, m_s);
               out_eol_d   = eol_s;
               out_eof_d   = in_eof;
            end else begin
               wr_en_s = 1'b1;
            end
         end
         if (in_eof) begin
            col_d = COL_ZERO;
            par_d = 1'b0;
            err_d = err_d | ~par_q;
         end else if (in_eol) begin
            col_d = COL_ZERO;
            par_d = ~par_q;
         end else begin
            par_d = par_q;
         end
      end else begin
         wr_en_s = 1'b0;
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         col_q       <= COL_ZERO;
         par_q       <= 1'b0;
         h_q         <= {DATA_WIDTH{1'b0}};
         rd_q        <= {DATA_WIDTH{1'b0}};
         out_data_q  <= {DATA_WIDTH{1'b0}};
         out_valid_q <= 1'b0;
         out_eol_q   <= 1'b0;
         out_eof_q   <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         col_q       <= col_d;
         par_q       <= par_d;
         h_q         <= h_d;
         rd_q        <= rd_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_eol_q   <= out_eol_d;
         out_eof_q   <= out_eof_d;
         err_q       <= err_d;
      end
   end

   // Line buffer write port; left unreset so it can map onto RAM
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         lbuf_q[addr_s] <= m_s;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_eol   = out_eol_q;
   assign out_eof   = out_eof_q;
   assign err       = err_q;

endmodule

// File: tb/tb_relu_maxpool2x2.sv
// Directed testbench for relu_maxpool2x2 with LINE_WIDTH=4 and hand-computed pooled results.
module tb_relu_maxpool2x2;
   localparam int DW = 16;
   localparam int LW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_eol;
   logic          in_eof;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_eol;
   logic          out_eof;
   logic          err;

   int n_checks = 0;
   int n_pass   = 0;

   logic          obs_valid;
   logic [DW-1:0] obs_data;
   logic          obs_eol;
   logic          obs_eof;
   logic          obs_err;

   relu_maxpool2x2 #(.DATA_WIDTH(DW), .LINE_WIDTH(LW)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_data(in_data), .in_eol(in_eol), .in_eof(in_eof),
      .out_valid(out_valid), .out_data(out_data), .out_eol(out_eol), .out_eof(out_eof),
      .err(err)
   );

   always #5 clk = ~clk;

   // Drive one cycle of input on the falling edge, then capture outputs just after the rising edge
   task automatic beat(input logic v, input logic [DW-1:0] d, input logic eol, input logic eof);
      @(negedge clk);
      in_valid = v;
      in_data  = d;
      in_eol   = eol;
      in_eof   = eof;
      @(posedge clk);
      #1;
      obs_valid = out_valid;
      obs_data  = out_data;
      obs_eol   = out_eol;
      obs_eof   = out_eof;
      obs_err   = err;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b0; in_valid = 1'b0; in_eol = 1'b0; in_eof = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0; in_valid = 1'b0; in_data = 16'd0; in_eol = 1'b0; in_eof = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid); else n_pass++;
      n_checks++; if (out_data !== 16'd0) $display("FAIL reset_data got %0d want 0", out_data); else n_pass++;
      n_checks++; if (out_eol !== 1'b0) $display("FAIL reset_eol got %b want 0", out_eol); else n_pass++;
      n_checks++; if (out_eof !== 1'b0) $display("FAIL reset_eof got %b want 0", out_eof); else n_pass++;
      n_checks++; if (err !== 1'b0) $display("FAIL reset_err got %b want 0", err); else n_pass++;
      @(negedge clk);
      reset = 1'b1;
   endtask

   // The 4x2 reference frame: rows (1,5,-3,2) and (4,-7,8,0) pool to 5 then 8 (eol, eof)
   task automatic basic_frame(input string tag, input logic gaps, input logic exp_err);
      logic [DW-1:0] d    [8];
      logic [DW-1:0] expd [8];
      logic [7:0]    eolv, eofv, expv;
      d    = '{16'd1, 16'd5, 16'hFFFD, 16'd2, 16'd4, 16'hFFF9, 16'd8, 16'd0};
      expd = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd5, 16'd0, 16'd8};
      eolv = 8'b1000_1000;
      eofv = 8'b1000_0000;
      expv = 8'b1010_0000;
      for (int i = 0; i < 8; i++) begin
         if (gaps) begin
            int ng;
            ng = int'($urandom_range(2, 1));
            for (int g = 0; g < ng; g++) begin
               beat(1'b0, 16'hBEEF, 1'b1, 1'b1);
               n_checks++; if (obs_valid !== 1'b0) $display("FAIL %s gap_valid[%0d] got %b want 0", tag, i, obs_valid); else n_pass++;
            end
         end
         beat(1'b1, d[i], eolv[i], eofv[i]);
         n_checks++; if (obs_valid !== expv[i]) $display("FAIL %s valid[%0d] got %b want %b", tag, i, obs_valid, expv[i]); else n_pass++;
         if (expv[i]) begin
            n_checks++; if (obs_data !== expd[i]) $display("FAIL %s data[%0d] got %0d want %0d", tag, i, obs_data, expd[i]); else n_pass++;
            n_checks++; if (obs_eol !== eolv[i]) $display("FAIL %s eol[%0d] got %b want %b", tag, i, obs_eol, eolv[i]); else n_pass++;
            n_checks++; if (obs_eof !== eofv[i]) $display("FAIL %s eof[%0d] got %b want %b", tag, i, obs_eof, eofv[i]); else n_pass++;
         end
      end
      beat(1'b0, 16'd0, 1'b0, 1'b0);
      n_checks++; if (obs_valid !== 1'b0) $display("FAIL %s idle_valid got %b want 0", tag, obs_valid); else n_pass++;
      n_checks++; if (obs_data !== 16'd8) $display("FAIL %s hold_data got %0d want 8", tag, obs_data); else n_pass++;
      n_checks++; if (obs_err !== exp_err) $display("FAIL %s err got %b want %b", tag, obs_err, exp_err); else n_pass++;
   endtask

   task automatic test_basic();
      basic_frame("basic", 1'b0, 1'b0);
   endtask

   task automatic test_all_negative();
      logic [DW-1:0] d [4];
      logic [3:0]    eolv, eofv, expv;
      d    = '{16'hFFFF, 16'hFFFE, 16'hFFFD, 16'h8000};
      eolv = 4'b1010;
      eofv = 4'b1000;
      expv = 4'b1000;
      for (int i = 0; i < 4; i++) begin
         beat(1'b1, d[i], eolv[i], eofv[i]);
         n_checks++; if (obs_valid !== expv[i]) $display("FAIL neg valid[%0d] got %b want %b", i, obs_valid, expv[i]); else n_pass++;
      end
      n_checks++; if (obs_data !== 16'd0) $display("FAIL neg data got %0d want 0", obs_data); else n_pass++;
      n_checks++; if (obs_eol !== 1'b1) $display("FAIL neg eol got %b want 1", obs_eol); else n_pass++;
      n_checks++; if (obs_eof !== 1'b1) $display("FAIL neg eof got %b want 1", obs_eof); else n_pass++;
      n_checks++; if (obs_err !== 1'b0) $display("FAIL neg err got %b want 0", obs_err); else n_pass++;
   endtask

   task automatic test_gaps();
      basic_frame("gaps", 1'b1, 1'b0);
   endtask

   task automatic test_odd_row();
      logic [DW-1:0] d [6];
      logic [5:0]    eolv, eofv, expv;
      d    = '{16'd7, 16'd9, 16'd4, 16'd1, 16'd2, 16'd3};
      eolv = 6'b100100;
      eofv = 6'b100000;
      expv = 6'b010000;
      for (int i = 0; i < 6; i++) begin
         beat(1'b1, d[i], eolv[i], eofv[i]);
         n_checks++; if (obs_valid !== expv[i]) $display("FAIL odd_row valid[%0d] got %b want %b", i, obs_valid, expv[i]); else n_pass++;
         n_checks++; if (obs_err !== (i >= 2)) $display("FAIL odd_row err[%0d] got %b want %b", i, obs_err, (i >= 2)); else n_pass++;
         if (expv[i]) begin
            n_checks++; if (obs_data !== 16'd9) $display("FAIL odd_row data got %0d want 9", obs_data); else n_pass++;
            n_checks++; if (obs_eol !== 1'b0) $display("FAIL odd_row eol got %b want 0", obs_eol); else n_pass++;
            n_checks++; if (obs_eof !== 1'b0) $display("FAIL odd_row eof got %b want 0", obs_eof); else n_pass++;
         end
      end
   endtask

   task automatic test_odd_count();
      logic [DW-1:0] d    [12];
      logic [DW-1:0] expd [12];
      logic [11:0]   eolv, eofv, expv;
      apply_reset();
      d    = '{16'd3, 16'd1, 16'd0, 16'd6, 16'd2, 16'd4, 16'hFFFF, 16'd5, 16'd9, 16'd9, 16'd9, 16'd9};
      expd = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd4, 16'd0, 16'd6, 16'd0, 16'd0, 16'd0, 16'd0};
      eolv = 12'b1000_1000_1000;
      eofv = 12'b1000_0000_0000;
      expv = 12'b0000_1010_0000;
      for (int i = 0; i < 12; i++) begin
         beat(1'b1, d[i], eolv[i], eofv[i]);
         n_checks++; if (obs_valid !== expv[i]) $display("FAIL odd_count valid[%0d] got %b want %b", i, obs_valid, expv[i]); else n_pass++;
         n_checks++; if (obs_err !== (i >= 11)) $display("FAIL odd_count err[%0d] got %b want %b", i, obs_err, (i >= 11)); else n_pass++;
         if (expv[i]) begin
            n_checks++; if (obs_data !== expd[i]) $display("FAIL odd_count data[%0d] got %0d want %0d", i, obs_data, expd[i]); else n_pass++;
            n_checks++; if (obs_eol !== eolv[i]) $display("FAIL odd_count eol[%0d] got %b want %b", i, obs_eol, eolv[i]); else n_pass++;
            n_checks++; if (obs_eof !== 1'b0) $display("FAIL odd_count eof[%0d] got %b want 0", i, obs_eof); else n_pass++;
         end
      end
      basic_frame("odd_count_next", 1'b0, 1'b1);
   endtask

   task automatic test_overlong();
      logic [DW-1:0] d    [12];
      logic [DW-1:0] expd [12];
      logic [11:0]   eolv, eofv, expv;
      apply_reset();
      d    = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd50, 16'd60, 16'd0, 16'd0, 16'd0, 16'd0, 16'd70, 16'd80};
      expd = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd2, 16'd0, 16'd4, 16'd0, 16'd0};
      eolv = 12'b1000_0010_0000;
      eofv = 12'b1000_0000_0000;
      expv = 12'b0010_1000_0000;
      for (int i = 0; i < 12; i++) begin
         beat(1'b1, d[i], eolv[i], eofv[i]);
         n_checks++; if (obs_valid !== expv[i]) $display("FAIL overlong valid[%0d] got %b want %b", i, obs_valid, expv[i]); else n_pass++;
         n_checks++; if (obs_err !== (i >= 4)) $display("FAIL overlong err[%0d] got %b want %b", i, obs_err, (i >= 4)); else n_pass++;
         if (expv[i]) begin
            n_checks++; if (obs_data !== expd[i]) $display("FAIL overlong data[%0d] got %0d want %0d", i, obs_data, expd[i]); else n_pass++;
            n_checks++; if (obs_eol !== 1'b0) $display("FAIL overlong eol[%0d] got %b want 0", i, obs_eol); else n_pass++;
         end
      end
   endtask

   task automatic test_reset_mid();
      beat(1'b1, 16'd1, 1'b0, 1'b0);
      beat(1'b1, 16'd5, 1'b0, 1'b0);
      beat(1'b1, 16'hFFFD, 1'b0, 1'b0);
      beat(1'b1, 16'd2, 1'b1, 1'b0);
      beat(1'b1, 16'd4, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b0; in_valid = 1'b0; in_eol = 1'b0; in_eof = 1'b0;
      #1;
      n_checks++; if (err !== 1'b0) $display("FAIL rst_mid async_err got %b want 0", err); else n_pass++;
      for (int k = 0; k < 2; k++) begin
         @(posedge clk);
         #1;
         n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_mid valid[%0d] got %b want 0", k, out_valid); else n_pass++;
         n_checks++; if (out_data !== 16'd0) $display("FAIL rst_mid data[%0d] got %0d want 0", k, out_data); else n_pass++;
      end
      @(negedge clk);
      reset = 1'b1;
      basic_frame("post_reset", 1'b0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_all_negative();
      test_gaps();
      test_odd_row();
      test_odd_count();
      test_overlong();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
